// File: rtl/line_buffer_window_if.sv
// Pixel-in / window-out bundle for line_buffer_window.
// master drives pixels and observes windows; slave is the window generator.
interface line_buffer_window_if #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 5
);
  logic                         in_valid;
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         out_valid;
  logic [K*K*DATA_WIDTH-1:0]    win;
  logic [5:0]                   out_row;
  logic [5:0]                   out_col;
  logic                         frame_done;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  win,
    input  out_row,
    input  out_col,
    input  frame_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output win,
    output out_row,
    output out_col,
    output frame_done
  );
endinterface

// File: rtl/line_buffer_window.sv
// Streaming KxK sliding-window generator over a square raster frame.
// Ports: clk, rst_n, mode (width select), frame_start, bus (pixel in / window out).
module line_buffer_window #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 32,
  parameter int K          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode,
  input  logic       frame_start,
  line_buffer_window_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [5:0] KM1 = 6'(K - 1);

  typedef logic [K-1:0][K-1:0][DW-1:0] win_t;
  typedef logic [K-1:0][DW-1:0]        col_t;

  function automatic logic [5:0] width_of(input logic [2:0] m);
    logic [5:0] w;
    unique case (1'b1)
      (m == 3'b000): w = 6'd32;
      (m == 3'b001): w = 6'd28;
      (m == 3'b010): w = 6'd14;
      (m == 3'b011): w = 6'd10;
      default:       w = 6'd5;
    endcase
    return w;
  endfunction

  logic [5:0]    w_q;
  logic [5:0]    col_q;
  logic [5:0]    row_q;
  logic          arm_q;

  logic [5:0]    w_cur;
  logic [5:0]    col_cur;
  logic [5:0]    row_cur;
  logic [AW-1:0] addr;
  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          in_win;

  logic [DW-1:0] mem [K-1][MAX_WIDTH];
  logic [DW-1:0] tap [K-1];
  col_t          col_new;

  win_t          win_q;
  logic          out_valid_q;
  logic          frame_done_q;
  logic [5:0]    out_row_q;
  logic [5:0]    out_col_q;

  // Width is sampled on the first cycle out of reset and on
  // frame_start; a same-cycle pixel already sees the new width.
  assign w_cur    = (frame_start || arm_q) ? width_of(mode) : w_q;
  assign col_cur  = frame_start ? 6'd0 : col_q;
  assign row_cur  = frame_start ? 6'd0 : row_q;
  assign addr     = col_cur[AW-1:0];
  assign accept   = bus.in_valid;
  assign last_col = (col_cur == w_cur - 6'd1);
  assign last_row = (row_cur == w_cur - 6'd1);
  assign in_win   = (row_cur >= KM1) && (col_cur >= KM1);

  always_comb begin
    for (int j = 0; j < K - 1; j++) begin
      tap[j] = mem[j][addr];
    end
  end

  // Row K-1 is the live pixel, row 0 the pixel K-1 lines above.
  always_comb begin
    col_new        = '0;
    col_new[K-1]   = bus.in_data;
    for (int r = 0; r < K - 1; r++) begin
      col_new[r] = tap[K-2-r];
    end
  end

  // Line delays: addressing by column makes each memory exactly one
  // line of the current width deep.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[0][addr] <= bus.in_data;
      for (int j = 1; j < K - 1; j++) begin
        mem[j][addr] <= tap[j-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= 6'd32;
      arm_q <= 1'b1;
      col_q <= '0;
      row_q <= '0;
    end else begin
      w_q   <= w_cur;
      arm_q <= 1'b0;
      if (accept) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? 6'd0 : row_cur + 6'd1;
        end else begin
          col_q <= col_cur + 6'd1;
          row_q <= row_cur;
        end
      end else begin
        col_q <= col_cur;
        row_q <= row_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      out_valid_q  <= accept && in_win;
      frame_done_q <= accept && in_win
                      && last_row && last_col;
      if (accept) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
          win_q[r][K-1] <= col_new[r];
        end
        if (in_win) begin
          out_row_q <= row_cur - KM1;
          out_col_q <= col_cur - KM1;
        end
      end
    end
  end

  assign bus.win        = win_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;

endmodule

// File: tb/tb_line_buffer_window.sv
// Randomized bench for line_buffer_window against a frame-image model.
// Windows are cut directly out of a stored copy of the frame.
module tb_line_buffer_window;

  localparam int DW = 8;
  localparam int MW = 32;
  localparam int K  = 5;
  localparam int WW = K * K * DW;

  logic       clk;
  logic       rst_n;
  logic [2:0] mode;
  logic       frame_start;

  line_buffer_window_if #(.DATA_WIDTH(DW), .K(K)) bus ();

  line_buffer_window #(
    .DATA_WIDTH(DW),
    .MAX_WIDTH (MW),
    .K         (K)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .frame_start(frame_start),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [WW-1:0] obs,
                     input logic [WW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] img [64][64];
  int            m_w;
  int            m_r;
  int            m_c;
  bit            m_arm;

  // Observation statistics
  int            nwin;
  int            ndone;
  bit            got_first;
  logic [WW-1:0] first_win;
  logic [WW-1:0] last_win;
  logic [5:0]    last_row;
  logic [5:0]    last_col;

  function automatic int width_of(input logic [2:0] m);
    case (m)
      3'b000:  return 32;
      3'b001:  return 28;
      3'b010:  return 14;
      3'b011:  return 10;
      default: return 5;
    endcase
  endfunction

  function automatic logic [DW-1:0] px(input logic [WW-1:0] w,
                                        input int r, input int c);
    return w[(r*K+c)*DW +: DW];
  endfunction

  task automatic clr_stats();
    nwin      = 0;
    ndone     = 0;
    got_first = 1'b0;
    first_win = '0;
    last_win  = '0;
    last_row  = '0;
    last_col  = '0;
  endtask

  task automatic step(input logic fs, input logic v,
                      input logic [DW-1:0] d, input logic [2:0] md);
    bit            e_valid;
    bit            e_done;
    logic [WW-1:0] e_win;
    int            e_row;
    int            e_col;
    e_valid = 1'b0;
    e_done  = 1'b0;
    e_win   = '0;
    e_row   = 0;
    e_col   = 0;
    frame_start  = fs;
    bus.in_valid = v;
    bus.in_data  = d;
    mode         = md;
    if (fs || m_arm) m_w = width_of(md);
    m_arm = 1'b0;
    if (fs) begin
      m_r = 0;
      m_c = 0;
    end
    if (v) begin
      img[m_r][m_c] = d;
      if (m_r >= K - 1 && m_c >= K - 1) begin
        e_valid = 1'b1;
        e_row   = m_r - (K - 1);
        e_col   = m_c - (K - 1);
        for (int rr = 0; rr < K; rr++)
          for (int cc = 0; cc < K; cc++)
            e_win[(rr*K+cc)*DW +: DW] = img[e_row+rr][e_col+cc];
        e_done = (m_r == m_w - 1) && (m_c == m_w - 1);
      end
      m_c++;
      if (m_c == m_w) begin
        m_c = 0;
        m_r++;
        if (m_r == m_w) m_r = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", WW'(bus.out_valid), WW'(e_valid));
    chk("frame_done", WW'(bus.frame_done), WW'(e_done));
    if (e_valid) begin
      chk("win", bus.win, e_win);
      chk("out_row", WW'(bus.out_row), WW'(e_row));
      chk("out_col", WW'(bus.out_col), WW'(e_col));
    end
    if (bus.out_valid) begin
      nwin++;
      if (!got_first) first_win = bus.win;
      got_first = 1'b1;
      last_win  = bus.win;
      last_row  = bus.out_row;
      last_col  = bus.out_col;
    end
    if (bus.frame_done) ndone++;
  endtask

  // Streams n accepted pixels valued (base+p+1)%256; the first one
  // optionally carries frame_start. Non-start cycles get a random
  // mode, which the design must ignore.
  task automatic stream(input int n, input bit fs_first,
                        input logic [2:0] md, input int duty,
                        input int base);
    int p;
    p = 0;
    while (p < n) begin
      if ((p == 0 && fs_first) || duty >= 100 ||
          $urandom_range(99) < duty) begin
        step(fs_first && p == 0, 1'b1, DW'((base + p + 1) % 256),
             (fs_first && p == 0) ? md : 3'($urandom_range(7)));
        p++;
      end else begin
        step(1'b0, 1'b0, DW'($urandom), 3'($urandom_range(7)));
      end
    end
  endtask

  logic [WW-1:0] s1_first;
  logic [WW-1:0] s1_last;

  initial begin
    rst_n        = 1'b0;
    mode         = 3'b000;
    frame_start  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    m_w = 32; m_r = 0; m_c = 0; m_arm = 1'b1;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", WW'(bus.out_valid), '0);
    chk("rst frame_done", WW'(bus.frame_done), '0);
    chk("rst win", bus.win, '0);
    chk("rst out_row", WW'(bus.out_row), '0);
    chk("rst out_col", WW'(bus.out_col), '0);
    rst_n = 1'b1;

    // 1: W=32 back-to-back
    clr_stats();
    stream(1024, 1'b1, 3'b000, 100, 0);
    chk("s1 windows", WW'(nwin), WW'(784));
    chk("s1 done", WW'(ndone), WW'(1));
    chk("s1 r0c0", WW'(px(first_win, 0, 0)), WW'(1));
    chk("s1 r4c4", WW'(px(first_win, 4, 4)), WW'(133));
    chk("s1 last row", WW'(last_row), WW'(27));
    chk("s1 last col", WW'(last_col), WW'(27));
    s1_first = first_win;
    s1_last  = last_win;

    // 2: W=14
    clr_stats();
    stream(196, 1'b1, 3'b010, 100, 0);
    chk("s2 windows", WW'(nwin), WW'(100));
    chk("s2 done", WW'(ndone), WW'(1));
    chk("s2 r0c0", WW'(px(first_win, 0, 0)), WW'(1));
    chk("s2 r4c4", WW'(px(first_win, 4, 4)), WW'(61));
    chk("s2 last r4c4", WW'(px(last_win, 4, 4)), WW'(196));

    // 3: W=32 with 50% bubbles
    clr_stats();
    stream(1024, 1'b1, 3'b000, 50, 0);
    chk("s3 windows", WW'(nwin), WW'(784));
    chk("s3 done", WW'(ndone), WW'(1));
    chk("s3 first", first_win, s1_first);
    chk("s3 last", last_win, s1_last);

    // 4: async reset mid-frame, then a clean frame
    clr_stats();
    stream(300, 1'b1, 3'b000, 100, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("s4 rst out_valid", WW'(bus.out_valid), '0);
    chk("s4 rst frame_done", WW'(bus.frame_done), '0);
    chk("s4 rst win", bus.win, '0);
    m_r = 0; m_c = 0; m_w = 32; m_arm = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    clr_stats();
    stream(1024, 1'b1, 3'b000, 100, 0);
    chk("s4 windows", WW'(nwin), WW'(784));
    chk("s4 done", WW'(ndone), WW'(1));
    chk("s4 first", first_win, s1_first);
    chk("s4 last", last_win, s1_last);

    // 5: frame_start mid-frame switching to W=10
    clr_stats();
    stream(500, 1'b1, 3'b000, 100, 0);
    chk("s5 old done", WW'(ndone), WW'(0));
    clr_stats();
    stream(100, 1'b1, 3'b011, 100, 500);
    chk("s5 windows", WW'(nwin), WW'(36));
    chk("s5 done", WW'(ndone), WW'(1));
    chk("s5 r0c0", WW'(px(first_win, 0, 0)), WW'(501 % 256));

    // 6: two W=28 frames with a single frame_start
    clr_stats();
    stream(1568, 1'b1, 3'b001, 100, 0);
    chk("s6 windows", WW'(nwin), WW'(1152));
    chk("s6 done", WW'(ndone), WW'(2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
